weight_sram_arbiter: RTL
========================

Name: weight_sram_arbiter

Overview:
- Shares one Weight_SRAM_controller port between NUM_REQ requesters, for example the weight loader DMA (writes) and PE-row weight fetchers (reads).
- Round-robin arbitration with one transaction in flight at a time.
- Holds address and data stable for the full SRAM access, captures read data on d_ready, and returns a per-requester response.
- Rejects out-of-range addresses and recovers from a lost completion by timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_BANKS, 25, SRAM banks behind the controller; valid bank index = addr[15:11] < NUM_BANKS.
- TIMEOUT_CYCLES, 16, WAIT cycles without completion before an error response.

Ports:
- clock  in  1  single clock.
- reset  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  request pending, one bit per requester; held until req_ready.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*32  packed; requester i at [32*i+31:32*i].
- req_wdata  in  NUM_REQ*32  packed write data.
- req_ready  out  NUM_REQ  one-cycle grant pulse; request captured.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_error  out  1  qualifies rsp_valid: range error or timeout.
- rsp_rdata  out  32  read data, valid with rsp_valid on reads; 0 on writes and errors.
- sram_addr  out  32  to controller addr.
- sram_w_d  out  32  to controller w_d.
- sram_w_en  out  1  to controller w_en.
- sram_r_en  out  1  to controller r_en.
- sram_r_d  in  32  from controller r_d.
- sram_d_ready  in  1  from controller d_ready.
- sram_w_done  in  1  from controller w_done.

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE, rr_ptr=0, all outputs 0, timeout counter 0. Reset mid-transaction aborts it with no response. Late d_ready/w_done pulses arriving after reset are ignored.
- All outputs are registered.

State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration:
  - Winner is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping mod NUM_REQ.
  - At the edge: latch write/addr/wdata/index, set rr_ptr = winner+1 mod NUM_REQ, and pulse req_ready[winner] in the next cycle.
  - If the address is invalid (addr[31:16]!=0 or addr[15:11]>=NUM_BANKS), go to RESP with error and issue nothing.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): sram_w_en=write or sram_r_en=~write (never both), with sram_addr/sram_w_d driven. Then go to WAIT.
- WAIT:
  - Enables low; sram_addr and sram_w_d held.
  - Completion is sram_w_done for writes and sram_d_ready for reads; the other pulse is ignored.
  - On completion, capture sram_r_d (reads) and go to RESP.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES, go to RESP with error.
  - Completion in the same cycle as timeout: completion wins, no error.
- RESP (1 cycle): rsp_valid[idx]=1, rsp_error and rsp_rdata set. Return to IDLE; the counter clears.
- Latency, valid request sampled at edge T:
  - req_ready at T+1 with ISSUE enables.
  - Controller completion pulse at T+3.
  - rsp_valid at T+4.
  - Next grant earliest at T+6, so one access per 5 cycles.
- Range error: req_ready at T+1, rsp_valid with rsp_error=1 at T+2; no sram_* enable asserted.
- The sram_addr upper bits are passed as latched (0 for valid requests).
- A requester dropping req_valid before req_ready is not a legal stimulus; the arbiter only samples in IDLE.

Optional Feature:
- Macro WEIGHT_ARB_PRIORITY_EN.
- Defined: requester 0 has strict priority. If req_valid[0]=1 in IDLE it wins regardless of rr_ptr, and rr_ptr is unchanged by its grant. Requesters 1..NUM_REQ-1 round-robin among themselves when requester 0 is idle.
- Undefined: plain round-robin over all requesters as above.

Test Plan:
- Single write, then read back: req 1 writes addr 0x0000_0805 data 0xDEADBEEF. Required: w_en pulse at T+1 with sram_addr=0x805 held through WAIT, then rsp_valid[1] at T+4, rsp_error=0. Read of the same address returns rsp_rdata=0xDEADBEEF.
- Round-robin fairness: all 4 req_valid held high continuously from reset. Required grant order 0,1,2,3,0, with consecutive grants 5 cycles apart.
- Range error: read at addr 0x0000_C800 (bank 25) and at 0x0001_0000. Required: rsp_valid with rsp_error=1 two cycles after sampling, rsp_rdata=0, sram_r_en never asserted.
- Timeout: stub controller never returns d_ready. Required: rsp_error=1 exactly TIMEOUT_CYCLES=16 WAIT cycles after ISSUE. A d_ready in the same cycle as the 16th WAIT cycle gives rsp_error=0 with the captured data.
- Reset mid-WAIT: reset=0 for 1 cycle during WAIT. Required: no rsp_valid, all outputs 0, a stray d_ready afterwards ignored, and rr_ptr=0 so requester 0 is served first next.
- With WEIGHT_ARB_PRIORITY_EN: requesters 0 and 2 always valid, rr_ptr=2. Required: requester 0 granted every time; requester 2 is never granted while req_valid[0]=1.

Source files
------------

// File: rtl/weight_sram_arbiter.sv
// weight_sram_arbiter
//   Shares a single Weight_SRAM_controller port between NUM_REQ requesters
//   (weight-loader DMA writes, PE-row fetcher reads). Round-robin grant, one
//   access in flight, address/data held through the access, read data
//   captured on d_ready, per-requester one-cycle response pulse.
//   Out-of-range addresses are rejected without touching the SRAM; a lost
//   completion is recovered by a TIMEOUT_CYCLES watchdog.
//
//   Optional build macro: WEIGHT_ARB_PRIORITY_EN
//     defined   -> requester 0 has strict priority and does not move rr_ptr;
//                  requesters 1..NUM_REQ-1 share round-robin.
//     undefined -> plain round-robin over all requesters.
//
// Ports
//   clock, reset         clock, synchronous active-low reset
//   req_valid/write      per-requester request and direction (1 = write)
//   req_addr/req_wdata   per-requester address / write data (packed [i][31:0])
//   req_ready            one-cycle grant pulse
//   rsp_valid            one-cycle completion pulse to the granted requester
//   rsp_error/rsp_rdata  response qualifier / read data (0 on writes, errors)
//   sram_*               controller port (addr, w_d, w_en, r_en, r_d,
//                        d_ready, w_done)

// Per-requester address range check: bank index lives in addr[15:11].
module weight_arb_addr_chk #(
  parameter int NUM_BANKS = 25
) (
  input  logic [31:0] addr,
  output logic        addr_ok
);
  localparam logic [5:0] NB = 6'(NUM_BANKS);
  assign addr_ok = (addr[31:16] == 16'd0) && ({1'b0, addr[15:11]} < NB);
endmodule

module weight_sram_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_BANKS      = 25,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0][31:0]  req_addr,
  input  logic [NUM_REQ-1:0][31:0]  req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_error,
  output logic [31:0]               rsp_rdata,
  output logic [31:0]               sram_addr,
  output logic [31:0]               sram_w_d,
  output logic                      sram_w_en,
  output logic                      sram_r_en,
  input  logic [31:0]               sram_r_d,
  input  logic                      sram_d_ready,
  input  logic                      sram_w_done
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW:0]   NREQ   = (IW+1)'(NUM_REQ);
  localparam logic [CW-1:0] TO_END = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]   cur_oh;
  logic                 cur_write;
  logic                 err_pend;
  logic [CW-1:0]        cnt;

  logic [NUM_REQ-1:0]   addr_ok;
  logic                 found;
  logic [IW-1:0]        win;
  logic [IW:0]          cand;
  logic [IW:0]          nxt;
  logic [IW-1:0]        nxt_ptr;
  logic [NUM_REQ-1:0]   win_oh;
  logic                 done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chk
    weight_arb_addr_chk #(.NUM_BANKS(NUM_BANKS)) u_chk (
      .addr    (req_addr[g]),
      .addr_ok (addr_ok[g])
    );
  end

  // Search upward from rr_ptr with wrap; first pending requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_valid[cand[IW-1:0]]
`ifdef WEIGHT_ARB_PRIORITY_EN
          && (cand != '0)
`endif
         ) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
`ifdef WEIGHT_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      found = 1'b1;
      win   = '0;
    end
`endif
  end

  always_comb begin
    nxt = {1'b0, win} + (IW+1)'(1);
    if (nxt == NREQ) nxt = '0;
    nxt_ptr = nxt[IW-1:0];
`ifdef WEIGHT_ARB_PRIORITY_EN
    // Priority grants leave the round-robin position of the others alone.
    if (win == '0) nxt_ptr = rr_ptr;
`endif
  end

  assign win_oh = NUM_REQ'(1) << win;
  // Only the completion matching the access direction counts.
  assign done   = cur_write ? sram_w_done : sram_d_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_oh    <= '0;
      cur_write <= 1'b0;
      err_pend  <= 1'b0;
      cnt       <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
      sram_addr <= '0;
      sram_w_d  <= '0;
      sram_w_en <= 1'b0;
      sram_r_en <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: if (found) begin
          cur_oh    <= win_oh;
          cur_write <= req_write[win];
          sram_addr <= req_addr[win];
          sram_w_d  <= req_wdata[win];
          req_ready <= win_oh;
          rr_ptr    <= nxt_ptr;
          if (addr_ok[win]) begin
            sram_w_en <= req_write[win];
            sram_r_en <= ~req_write[win];
            state     <= ISSUE;
          end else begin
            // Nothing reaches the SRAM; respond with error one cycle later.
            err_pend  <= 1'b1;
            state     <= RESP;
          end
        end
        ISSUE: begin
          sram_w_en <= 1'b0;
          sram_r_en <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          // Completion is tested first so it wins on the timeout cycle.
          if (done) begin
            rsp_valid <= cur_oh;
            rsp_error <= 1'b0;
            rsp_rdata <= cur_write ? 32'd0 : sram_r_d;
            state     <= RESP;
          end else if (cnt == TO_END) begin
            rsp_valid <= cur_oh;
            rsp_error <= 1'b1;
            rsp_rdata <= 32'd0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (err_pend) begin
            err_pend  <= 1'b0;
            rsp_valid <= cur_oh;
            rsp_error <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            rsp_valid <= '0;
            rsp_error <= 1'b0;
            rsp_rdata <= 32'd0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
